// File: rtl/weight_load_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_load_control_unit: streams weight tiles into double-buffered slots |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module weight_load_control_unit #(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 16,
  parameter int TILE_W   = 8
) (
  input  logic                        clk_i,
  input  logic                        rstN_i,
  input  logic                        start_i,
  input  logic [ADDR_W-1:0]           base_addr_i,
  input  logic [TILE_W-1:0]           num_tiles_i,
  input  logic                        next_weight_tile_i,
  input  logic [8*MUL_SIZE-1:0]       weight_mem_data_i,
  output logic                        weight_mem_rd_en_o,
  output logic [ADDR_W-1:0]           weight_mem_addr_o,
  output logic                        load_weights_o,
  output logic [$clog2(MUL_SIZE)-1:0] load_row_o,
  output logic                        load_slot_o,
  output logic [8*MUL_SIZE-1:0]       weight_row_o,
  output logic                        compute_weights_rdy_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int                 c_ROW_W    = $clog2(MUL_SIZE);
  localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(MUL_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_WAIT_SLOT = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [TILE_W-1:0]    r_tiles_left;
  logic [c_ROW_W-1:0]   r_rd_row, r_d1_row, r_ld_row;
  logic                 r_rd_slot, r_d1_slot, r_ld_slot;
  logic                 r_d1_vld, r_ld_vld;
  logic [8*MUL_SIZE-1:0] r_row_data;
  logic [1:0]           r_slots_used, r_tiles_ready, w_slots_nxt, w_tiles_nxt;
  logic                 r_rdy, r_done, r_err;

  logic w_start_ok, w_fetch, w_tile_first, w_tile_last_rd, w_tile_done, w_release;

  assign w_start_ok     = (r_state == S_IDLE) && start_i && (num_tiles_i != '0);
  assign w_fetch        = (r_state == S_FETCH);
  assign w_tile_first   = w_fetch && (r_rd_row == '0);
  assign w_tile_last_rd = w_fetch && (r_rd_row == c_LAST_ROW);
  assign w_tile_done    = r_ld_vld && (r_ld_row == c_LAST_ROW);
  // A release only counts when a completed tile exists to be released
  assign w_release      = next_weight_tile_i && (r_tiles_ready != 2'd0);

  always_comb begin
    w_slots_nxt = r_slots_used;
    if (w_tile_first && !w_release && (r_slots_used != 2'd2))
      w_slots_nxt = r_slots_used + 2'd1;
    else if (w_release && !w_tile_first && (r_slots_used != 2'd0))
      w_slots_nxt = r_slots_used - 2'd1;

    w_tiles_nxt = r_tiles_ready;
    if (w_tile_done && !w_release && (r_tiles_ready != 2'd2))
      w_tiles_nxt = r_tiles_ready + 2'd1;
    else if (w_release && !w_tile_done)
      w_tiles_nxt = r_tiles_ready - 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok)
          w_state_nxt = (w_slots_nxt < 2'd2) ? S_FETCH : S_WAIT_SLOT;
      end
      S_FETCH: begin
        if (w_tile_last_rd) begin
          if (r_tiles_left == TILE_W'(1))
            w_state_nxt = S_FINISH;
          else
            w_state_nxt = (w_slots_nxt < 2'd2) ? S_FETCH : S_WAIT_SLOT;
        end
      end
      S_WAIT_SLOT: begin
        if (w_slots_nxt < 2'd2)
          w_state_nxt = S_FETCH;
      end
      S_FINISH: begin
        if (w_tile_done)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      r_addr        <= '0;
      r_tiles_left  <= '0;
      r_rd_row      <= '0;
      r_rd_slot     <= 1'b0;
      r_d1_vld      <= 1'b0;
      r_d1_row      <= '0;
      r_d1_slot     <= 1'b0;
      r_ld_vld      <= 1'b0;
      r_ld_row      <= '0;
      r_ld_slot     <= 1'b0;
      r_row_data    <= '0;
      r_slots_used  <= 2'd0;
      r_tiles_ready <= 2'd0;
      r_rdy         <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_addr       <= base_addr_i;
        r_tiles_left <= num_tiles_i;
        r_rd_row     <= '0;
      end else if (w_fetch) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_rd_row <= w_tile_last_rd ? '0 : r_rd_row + c_ROW_W'(1);
        if (w_tile_last_rd) begin
          r_tiles_left <= r_tiles_left - TILE_W'(1);
          r_rd_slot    <= ~r_rd_slot;
        end
      end

      // Memory returns data one cycle after the strobe; register it a second time
      r_d1_vld  <= w_fetch;
      r_d1_row  <= r_rd_row;
      r_d1_slot <= r_rd_slot;
      r_ld_vld  <= r_d1_vld;
      r_ld_row  <= r_d1_row;
      r_ld_slot <= r_d1_slot;
      if (r_d1_vld)
        r_row_data <= weight_mem_data_i;

      r_slots_used  <= w_slots_nxt;
      r_tiles_ready <= w_tiles_nxt;
      r_rdy         <= (w_tiles_nxt != 2'd0);
      r_done        <= ((r_state == S_FINISH) && w_tile_done) ||
                       ((r_state == S_IDLE) && start_i && (num_tiles_i == '0));
      r_err         <= r_err | (next_weight_tile_i && (r_tiles_ready == 2'd0));
    end
  end

  assign weight_mem_rd_en_o    = w_fetch;
  assign weight_mem_addr_o     = r_addr;
  assign load_weights_o        = r_ld_vld;
  assign load_row_o            = r_ld_row;
  assign load_slot_o           = r_ld_slot;
  assign weight_row_o          = r_row_data;
  assign compute_weights_rdy_o = r_rdy;
  assign busy_o                = (r_state != S_IDLE);
  assign done_o                = r_done;
  assign err_o                 = r_err;

endmodule
`default_nettype wire

// File: tb/tb_weight_load_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_weight_load_control_unit: directed + random bench with reference model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_weight_load_control_unit;

  localparam int MUL = 32;
  localparam int AW  = 16;
  localparam int TW  = 8;
  localparam int DW  = 8 * MUL;
  localparam int RW  = $clog2(MUL);

  logic          clk = 1'b0;
  logic          rstN_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [TW-1:0] num_tiles_i;
  logic          next_weight_tile_i;
  logic [DW-1:0] weight_mem_data_i;
  logic          weight_mem_rd_en_o;
  logic [AW-1:0] weight_mem_addr_o;
  logic          load_weights_o;
  logic [RW-1:0] load_row_o;
  logic          load_slot_o;
  logic [DW-1:0] weight_row_o;
  logic          compute_weights_rdy_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  always #5 clk = ~clk;

  weight_load_control_unit #(.MUL_SIZE(MUL), .ADDR_W(AW), .TILE_W(TW)) dut (
    .clk_i                 (clk),
    .rstN_i                (rstN_i),
    .start_i               (start_i),
    .base_addr_i           (base_addr_i),
    .num_tiles_i           (num_tiles_i),
    .next_weight_tile_i    (next_weight_tile_i),
    .weight_mem_data_i     (weight_mem_data_i),
    .weight_mem_rd_en_o    (weight_mem_rd_en_o),
    .weight_mem_addr_o     (weight_mem_addr_o),
    .load_weights_o        (load_weights_o),
    .load_row_o            (load_row_o),
    .load_slot_o           (load_slot_o),
    .weight_row_o          (weight_row_o),
    .compute_weights_rdy_o (compute_weights_rdy_o),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .err_o                 (err_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;

  // Reference model: job = flat count of rows to read; expected loads kept as a timed queue
  typedef struct {
    int            due;
    int            row;
    bit            slot;
    logic [AW-1:0] addr;
  } ld_t;

  ld_t           lq[$];
  bit            m_busy, m_stalled, m_slot_ptr, m_done, m_rdy, m_err;
  int            m_rows_left, m_rd_cnt, m_slots, m_ready;
  logic [AW-1:0] m_addr;
  bit            rd_pend;
  logic [AW-1:0] rd_pend_addr;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    logic [DW-1:0] p;
    for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = {a ^ AW'(i * 4099), ~a};
    return p;
  endfunction

  function automatic logic [DW-1:0] garbage();
    logic [DW-1:0] p;
    for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    lq.delete();
    m_busy = 0; m_stalled = 0; m_slot_ptr = 0; m_done = 0; m_rdy = 0; m_err = 0;
    m_rows_left = 0; m_rd_cnt = 0; m_slots = 0; m_ready = 0; m_addr = '0;
    rd_pend = 0; rd_pend_addr = '0;
  endtask

  function automatic bit m_fetching();
    return m_busy && (m_rows_left > 0) && !m_stalled;
  endfunction

  task automatic check_cycle();
    bit exp_ld;
    exp_ld = (lq.size() > 0) && (lq[0].due == cyc);
    chk("rd_en", weight_mem_rd_en_o, m_fetching());
    if (m_fetching()) chk("rd_addr", weight_mem_addr_o, m_addr);
    chk("load_weights", load_weights_o, exp_ld);
    if (exp_ld) begin
      chk("load_row", load_row_o, lq[0].row);
      chk("load_slot", load_slot_o, lq[0].slot);
      chk("weight_row", weight_row_o, pattern(lq[0].addr));
    end
    chk("busy", busy_o, m_busy);
    chk("done", done_o, m_done);
    chk("rdy", compute_weights_rdy_o, m_rdy);
    chk("err", err_o, m_err);
    if (done_o === 1'b1) n_done++;
  endtask

  task automatic model_advance(input bit st, input logic [AW-1:0] ba,
                               input logic [TW-1:0] nt, input bit rel);
    bit fetch, cmpl, rel_ok;
    int row, sl, rd;
    fetch  = m_fetching();
    cmpl   = 0;
    if ((lq.size() > 0) && (lq[0].due == cyc)) begin
      cmpl = (lq[0].row == MUL - 1);
      void'(lq.pop_front());
    end
    rel_ok = rel && (m_ready > 0);
    if (rel && (m_ready == 0)) m_err = 1;
    row = m_rd_cnt % MUL;
    sl  = m_slots + ((fetch && row == 0) ? 1 : 0) - (rel_ok ? 1 : 0);
    rd  = m_ready + (cmpl ? 1 : 0) - (rel_ok ? 1 : 0);
    if (sl > 2) sl = 2;
    if (sl < 0) sl = 0;
    if (rd > 2) rd = 2;
    if (rd < 0) rd = 0;
    m_done = 0;
    if (fetch) begin
      lq.push_back('{due: cyc + 2, row: row, slot: m_slot_ptr, addr: m_addr});
      m_addr++;
      m_rd_cnt++;
      m_rows_left--;
      if (row == MUL - 1) begin
        m_slot_ptr = ~m_slot_ptr;
        if (m_rows_left > 0) m_stalled = (sl >= 2);
      end
    end else if (m_busy && m_stalled) begin
      if (sl < 2) m_stalled = 0;
    end else if (m_busy && (m_rows_left == 0) && cmpl) begin
      m_busy = 0;
      m_done = 1;
    end else if (!m_busy && st) begin
      if (nt == 0) m_done = 1;
      else begin
        m_busy      = 1;
        m_rows_left = int'(nt) * MUL;
        m_addr      = ba;
        m_rd_cnt    = 0;
        m_stalled   = (sl >= 2);
      end
    end
    m_slots = sl;
    m_ready = rd;
    m_rdy   = (rd != 0);
  endtask

  task automatic step(input bit st, input logic [AW-1:0] ba, input logic [TW-1:0] nt, input bit rel);
    @(posedge clk);
    #1;
    weight_mem_data_i  = rd_pend ? pattern(rd_pend_addr) : garbage();
    start_i            = st;
    base_addr_i        = ba;
    num_tiles_i        = nt;
    next_weight_tile_i = rel;
    @(negedge clk);
    check_cycle();
    rd_pend      = (weight_mem_rd_en_o === 1'b1);
    rd_pend_addr = weight_mem_addr_o;
    model_advance(st, ba, nt, rel);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_rd_en"}, weight_mem_rd_en_o, 0);
    chk({tag, "_addr"}, weight_mem_addr_o, 0);
    chk({tag, "_load"}, load_weights_o, 0);
    chk({tag, "_row"}, load_row_o, 0);
    chk({tag, "_slot"}, load_slot_o, 0);
    chk({tag, "_wrow"}, weight_row_o, 0);
    chk({tag, "_rdy"}, compute_weights_rdy_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // Called at a falling edge: reset asserts mid-cycle and is checked before any clock edge
  task automatic apply_reset(input string tag);
    #2 rstN_i = 1'b0;
    #1 reset_outputs_check(tag);
    model_reset();
    @(negedge clk);
    rstN_i = 1'b1;
    cyc += 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base_before;
    bit  hit;
    logic [AW-1:0] rb;

    rstN_i = 1'b0;
    start_i = 1'b0; base_addr_i = '0; num_tiles_i = '0; next_weight_tile_i = 1'b0;
    weight_mem_data_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_outputs_check("por");
    rstN_i = 1'b1;

    // Single tile from 0x0010: reads 1..32, loads 3..34, ready from 35
    step(1'b1, 16'h0010, 8'd1, 1'b0);
    idle(40);
    chk("a_done_count", n_done, 1);

    // Three tiles with no release stall in front of the third tile
    apply_reset("b_rst");
    base_before = n_done;
    step(1'b1, 16'h1200, 8'd3, 1'b0);
    idle(120);
    chk("b_stalled_rd_en", weight_mem_rd_en_o, 0);
    chk("b_stalled_busy", busy_o, 1);
    step(1'b0, '0, '0, 1'b1);
    idle(45);
    chk("b_done_count", n_done - base_before, 1);

    // Address wrap past 0xFFFF
    apply_reset("c_rst");
    step(1'b1, 16'hFFF0, 8'd1, 1'b0);
    idle(40);

    // Release coinciding with completion of the second tile
    apply_reset("d_rst");
    step(1'b1, 16'h0400, 8'd2, 1'b0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if ((lq.size() > 0) && (lq[0].due == cyc) && (lq[0].row == MUL - 1) && (m_ready == 1)) begin
        step(1'b0, '0, '0, 1'b1);
        hit = 1;
      end else begin
        step(1'b0, '0, '0, 1'b0);
      end
    end
    chk("d_coincide_reached", hit, 1);
    idle(1);
    chk("d_rdy_held", compute_weights_rdy_o, 1);

    // Release with nothing ready
    apply_reset("e_rst");
    step(1'b0, '0, '0, 1'b1);
    idle(1);
    chk("e_err", err_o, 1);
    idle(5);
    chk("e_err_sticky", err_o, 1);

    // Reset in the middle of a fetch, then a fresh job restarts at slot 0 row 0
    apply_reset("f_rst0");
    step(1'b1, 16'h2000, 8'd2, 1'b0);
    for (int i = 0; i < 100 && m_rd_cnt < 11; i++) idle(1);
    chk("f_mid_fetch", weight_mem_rd_en_o, 1);
    apply_reset("f_rst");
    step(1'b1, 16'h3000, 8'd1, 1'b0);
    idle(40);

    // Randomized jobs, start attempts and releases
    apply_reset("g_rst");
    for (int i = 0; i < 1500; i++) begin
      rb = AW'($urandom());
      step($urandom_range(0, 15) == 0, rb, TW'($urandom_range(0, 4)), $urandom_range(0, 11) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
